// File: rtl/solution_player_pkg.sv
// Shared types and constants for the 2x3 sliding-puzzle replay block and its solver.
package solution_player_pkg;

  localparam int BOARD_W       = 18;
  localparam int CELL_W        = 3;
  localparam int NUM_CELLS     = 6;
  localparam int CNT_W         = 5;
  localparam int ORD_W         = 40;
  localparam int MAX_DEPTH_DEF = 20;

  // Direction the blank travels.
  typedef enum logic [1:0] {
    UP    = 2'b00,
    RIGHT = 2'b01,
    DOWN  = 2'b10,
    LEFT  = 2'b11
  } move_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_NOCOMP  = 2'b01,
    ERR_BADCNT  = 2'b10,
    ERR_ILLEGAL = 2'b11
  } err_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EMIT  = 3'd1,
    STEP  = 3'd2,
    CHECK = 3'd3,
    FIN   = 3'd4
  } state_t;

endpackage

// File: rtl/solution_player_if.sv
// Request inputs, beat stream and status of the replay block; master is the player side.
interface solution_player_if;
  import solution_player_pkg::*;

  logic                 start;
  logic                 comp;
  logic [CNT_W-1:0]     cnt;
  logic [ORD_W-1:0]     ord;
  logic [BOARD_W-1:0]   begin_board;
  logic [BOARD_W-1:0]   goal_board;
  logic                 out_ready;
  logic                 out_valid;
  logic [BOARD_W-1:0]   out_board;
  logic [CNT_W-1:0]     out_step;
  logic [1:0]           out_move;
  logic                 busy;
  logic                 done;
  logic                 ok;
  logic [1:0]           err;

  modport master (
    input  start, comp, cnt, ord, begin_board, goal_board, out_ready,
    output out_valid, out_board, out_step, out_move, busy, done, ok, err
  );

  modport slave (
    output start, comp, cnt, ord, begin_board, goal_board, out_ready,
    input  out_valid, out_board, out_step, out_move, busy, done, ok, err
  );

endinterface

// File: rtl/solution_player_pz_move.sv
// Combinational single move: swaps the blank with its neighbour, flags moves off the board.
module pz_move
  import solution_player_pkg::*;
(
  input  logic [BOARD_W-1:0] board,
  input  logic [2:0]         blank,
  input  move_t              move,
  output logic [BOARD_W-1:0] next_board,
  output logic [2:0]         next_blank,
  output logic               illegal
);

  logic [2:0] nb;

  always_comb begin
    nb         = blank;
    illegal    = 1'b0;
    next_board = board;
    next_blank = blank;

    case (move)
      UP:      if (blank < 3'd3) illegal = 1'b1; else nb = blank - 3'd3;
      DOWN:    if (blank >= 3'd3) illegal = 1'b1; else nb = blank + 3'd3;
      RIGHT:   if (blank == 3'd2 || blank == 3'd5) illegal = 1'b1; else nb = blank + 3'd1;
      LEFT:    if (blank == 3'd0 || blank == 3'd3) illegal = 1'b1; else nb = blank - 3'd1;
      default: illegal = 1'b1;
    endcase

    // A blank index past the last cell means the caller lost track of the board.
    if (blank > 3'd5) illegal = 1'b1;

    if (!illegal) begin
      next_board[CELL_W*blank +: CELL_W] = board[CELL_W*nb +: CELL_W];
      next_board[CELL_W*nb +: CELL_W]    = board[CELL_W*blank +: CELL_W];
      next_blank = nb;
    end
  end

endmodule

// File: rtl/solution_player.sv
// Replays a solver move list as a valid/ready stream of boards, one beat per two cycles,
// then reports whether the final board matches the goal.
module solution_player
  import solution_player_pkg::*;
#(
  parameter int MAX_DEPTH = MAX_DEPTH_DEF
)
(
  input  logic clk,
  input  logic rst_n,
  solution_player_if.master io
);

  localparam logic [CNT_W:0] MAX_CNT = (CNT_W+1)'(MAX_DEPTH);

  state_t               state, next_state;
  logic [CNT_W-1:0]     cnt_q;
  logic [ORD_W-1:0]     ord_q;
  logic [BOARD_W-1:0]   goal_q;
  logic [BOARD_W-1:0]   board_q;
  logic [2:0]           blank_q;
  logic [CNT_W-1:0]     step_q;
  logic [1:0]           move_q;
  logic                 ok_q;
  err_t                 err_q;

  logic [2:0]           zero_cnt;
  logic [2:0]           blank_pos;
  logic                 bad_cnt;
  logic                 bad_blank;
  logic [ORD_W-1:0]     ord_sh;
  logic [1:0]           cur_move;
  logic [BOARD_W-1:0]   nxt_board;
  logic [2:0]           nxt_blank;
  logic                 mv_illegal;

  always_comb begin
    zero_cnt  = '0;
    blank_pos = '0;
    for (int p = 0; p < NUM_CELLS; p++) begin
      if (io.begin_board[CELL_W*p +: CELL_W] == '0) begin
        zero_cnt  = zero_cnt + 3'd1;
        blank_pos = 3'(p);
      end
    end
  end

  assign bad_cnt   = {1'b0, io.cnt} > MAX_CNT;
  assign bad_blank = (zero_cnt != 3'd1);

  assign ord_sh   = ord_q >> {step_q, 1'b0};
  assign cur_move = ord_sh[1:0];

  pz_move u_move (
    .board      (board_q),
    .blank      (blank_q),
    .move       (move_t'(cur_move)),
    .next_board (nxt_board),
    .next_blank (nxt_blank),
    .illegal    (mv_illegal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state   = state;
    io.out_valid = 1'b0;
    io.busy      = 1'b1;
    io.done      = 1'b0;
    case (state)
      IDLE: begin
        io.busy = 1'b0;
        if (io.start) next_state = (!io.comp || bad_cnt || bad_blank) ? FIN : EMIT;
      end
      EMIT: begin
        io.out_valid = 1'b1;
        if (io.out_ready) next_state = (step_q == cnt_q) ? CHECK : STEP;
      end
      STEP:    next_state = mv_illegal ? FIN : EMIT;
      CHECK:   next_state = FIN;
      FIN: begin
        io.done    = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      ord_q   <= '0;
      goal_q  <= '0;
      board_q <= '0;
      blank_q <= '0;
      step_q  <= '0;
      move_q  <= '0;
      ok_q    <= 1'b0;
      err_q   <= ERR_NONE;
    end else begin
      case (state)
        IDLE: if (io.start) begin
          cnt_q   <= io.cnt;
          ord_q   <= io.ord;
          goal_q  <= io.goal_board;
          board_q <= io.begin_board;
          blank_q <= blank_pos;
          step_q  <= '0;
          move_q  <= '0;
          ok_q    <= 1'b0;
          if (!io.comp)     err_q <= ERR_NOCOMP;
          else if (bad_cnt) err_q <= ERR_BADCNT;
          else if (bad_blank) err_q <= ERR_ILLEGAL;
          else              err_q <= ERR_NONE;
        end
        STEP: begin
          if (mv_illegal) begin
            err_q <= ERR_ILLEGAL;
          end else begin
            board_q <= nxt_board;
            blank_q <= nxt_blank;
            step_q  <= step_q + 1'b1;
            move_q  <= cur_move;
          end
        end
        // A mismatch leaves err at NONE; ok alone tells the caller.
        CHECK: ok_q <= (board_q == goal_q);
        default: ;
      endcase
    end
  end

  assign io.out_board = board_q;
  assign io.out_step  = step_q;
  assign io.out_move  = move_q;
  assign io.ok        = ok_q;
  assign io.err       = err_q;

endmodule
